// File: rtl/mul_pkg.sv
// Shared definitions for the repeated-addition multiplier: operand widths
// and the controller state encodings.
package mul_pkg;

  localparam int MUL_WIDTH = 16;

  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

  localparam int MUL_PWIDTH = prod_width(MUL_WIDTH);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } ctrl_state_e;

endpackage

// File: rtl/down_counter.sv
// B operand register: loadable down counter that saturates at zero and
// exposes a combinational zero flag.
module down_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] data,
  output logic             zero
);

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_next_s;

  assign zero = (count_r == {WIDTH{1'b0}});

  // Next count: load wins over decrement, decrement stops at zero.
  always_comb begin
    count_next_s = count_r;
    if (load) begin
      count_next_s = data;
    end else if (dec && !zero) begin
      count_next_s = count_r - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_next_s = count_r;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {WIDTH{1'b0}};
    end else begin
      count_r <= count_next_s;
    end
  end

endmodule

// File: rtl/mul_datapath.sv
// Repeated-addition multiplier datapath: A/B operand registers, product
// accumulator and a result register that latches on the rising edge of done.
module mul_datapath
  import mul_pkg::*;
#(
  parameter int WIDTH  = MUL_WIDTH,
  parameter int PWIDTH = prod_width(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              lda,
  input  logic              ldb,
  input  logic              ldp,
  input  logic              clrp,
  input  logic              decb,
  input  logic              done,
  output logic              eqz,
  output logic [PWIDTH-1:0] product,
  output logic [PWIDTH-1:0] result,
  output logic              result_valid
);

  logic [WIDTH-1:0]  a_r;
  logic [PWIDTH-1:0] p_r;
  logic [PWIDTH-1:0] p_next_s;
  logic [PWIDTH-1:0] addend_s;
  logic [PWIDTH-1:0] result_r;
  logic              result_valid_r;
  logic              done_q_r;
  logic              armed_r;
  logic              b_zero_s;
  logic              done_rise_s;

  down_counter #(.WIDTH(WIDTH)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ldb),
    .dec   (decb),
    .data  (data_in),
    .zero  (b_zero_s)
  );

  assign eqz          = b_zero_s;
  assign product      = p_r;
  assign result       = result_r;
  assign result_valid = result_valid_r;

  assign addend_s = {{(PWIDTH-WIDTH){1'b0}}, a_r};

  // armed_r blocks a completion on the first edge after reset, so a done
  // left high across a reset cannot publish a stale result.
  assign done_rise_s = done && !done_q_r && armed_r;

  // Accumulator next value: clear beats accumulate; B==0 freezes P.
  always_comb begin
    p_next_s = p_r;
    if (clrp) begin
      p_next_s = {PWIDTH{1'b0}};
    end else if (ldp && !b_zero_s) begin
      p_next_s = p_r + addend_s;
    end else begin
      p_next_s = p_r;
    end
  end

  // A operand and P accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= {WIDTH{1'b0}};
      p_r <= {PWIDTH{1'b0}};
    end else begin
      if (lda) begin
        a_r <= data_in;
      end
      p_r <= p_next_s;
    end
  end

  // Completion tracking, result latch and one-cycle valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q_r       <= 1'b0;
      armed_r        <= 1'b0;
      result_r       <= {PWIDTH{1'b0}};
      result_valid_r <= 1'b0;
    end else begin
      done_q_r       <= done;
      armed_r        <= 1'b1;
      result_valid_r <= done_rise_s;
      if (done_rise_s) begin
        result_r <= p_r;
      end
    end
  end

endmodule

// File: tb/tb_mul_datapath.sv
// Directed bench for mul_datapath; result pulses are checked by a scoreboard
// monitor against expected products queued by the stimulus.
module tb_mul_datapath;

  localparam int W  = 16;
  localparam int PW = 32;
  localparam int SW = 4;
  localparam int SPW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic          lda = 1'b0, ldb = 1'b0, ldp = 1'b0, clrp = 1'b0, decb = 1'b0, done = 1'b0;
  logic          eqz;
  logic [PW-1:0] product, result;
  logic          result_valid;

  logic [SW-1:0]  s_data = '0;
  logic           s_lda = 1'b0, s_ldb = 1'b0, s_ldp = 1'b0, s_clrp = 1'b0, s_decb = 1'b0, s_done = 1'b0;
  logic           s_eqz;
  logic [SPW-1:0] s_product, s_result;
  logic           s_result_valid;

  int total = 0;
  int bad = 0;
  logic [PW-1:0]  exp_q[$];
  logic [SPW-1:0] s_exp_q[$];

  always #5 clk = ~clk;

  mul_datapath #(.WIDTH(W), .PWIDTH(PW)) u_dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .lda(lda), .ldb(ldb),
    .ldp(ldp), .clrp(clrp), .decb(decb), .done(done), .eqz(eqz),
    .product(product), .result(result), .result_valid(result_valid)
  );

  mul_datapath #(.WIDTH(SW), .PWIDTH(SPW)) u_small (
    .clk(clk), .rst_n(rst_n), .data_in(s_data), .lda(s_lda), .ldb(s_ldb),
    .ldp(s_ldp), .clrp(s_clrp), .decb(s_decb), .done(s_done), .eqz(s_eqz),
    .product(s_product), .result(s_result), .result_valid(s_result_valid)
  );

  // Scoreboard monitor for the full-width instance.
  always @(negedge clk) begin
    if (result_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pulse_unexpected: result=%0d, no result expected", result);
      end else begin
        logic [PW-1:0] e;
        e = exp_q.pop_front();
        if (result !== e) begin
          bad++;
          $display("FAIL result_value: got %0d expected %0d", result, e);
        end
      end
    end
  end

  // Scoreboard monitor for the narrow instance.
  always @(negedge clk) begin
    if (s_result_valid === 1'b1) begin
      total++;
      if (s_exp_q.size() == 0) begin
        bad++;
        $display("FAIL small_pulse_unexpected: result=%0d, no result expected", s_result);
      end else begin
        logic [SPW-1:0] e;
        e = s_exp_q.pop_front();
        if (s_result !== e) begin
          bad++;
          $display("FAIL small_result_value: got %0d expected %0d", s_result, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ops(input logic [W-1:0] a, input logic [W-1:0] b);
    lda = 1'b1; data_in = a; tick(); lda = 1'b0;
    ldb = 1'b1; data_in = b; tick(); ldb = 1'b0;
    clrp = 1'b1; tick(); clrp = 1'b0;
  endtask

  // Hold ldp+decb until eqz; returns the number of accumulate cycles.
  task automatic run_to_zero(output int n);
    n = 0;
    ldp = 1'b1; decb = 1'b1;
    while (eqz !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    ldp = 1'b0; decb = 1'b0;
  endtask

  task automatic finish_op(input logic [PW-1:0] exp);
    exp_q.push_back(exp);
    done = 1'b1;
    repeat (3) tick();
    done = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    #2;
    chk("reset_eqz", eqz, 1);
    chk("reset_product", product, 0);
    chk("reset_result", result, 0);
    chk("reset_valid", result_valid, 0);
    #11 rst_n = 1'b1;
    tick();

    // 17 * 5
    load_ops(16'd17, 16'd5);
    run_to_zero(n);
    chk("basic_cycles", n, 5);
    chk("basic_product", product, 85);
    chk("basic_eqz", eqz, 1);
    finish_op(32'd85);
    chk("basic_result_hold", result, 85);

    // done again (fall then rise) must re-publish
    finish_op(32'd85);

    // extra cycles after B reaches zero
    load_ops(16'd9, 16'd3);
    ldp = 1'b1; decb = 1'b1;
    repeat (5) tick();
    ldp = 1'b0; decb = 1'b0;
    chk("guard_product", product, 27);
    chk("guard_eqz_no_wrap", eqz, 1);
    finish_op(32'd27);

    // B = 0
    lda = 1'b1; data_in = 16'd123; tick(); lda = 1'b0;
    ldb = 1'b1; data_in = 16'd0; tick(); ldb = 1'b0;
    chk("bzero_eqz", eqz, 1);
    clrp = 1'b1; tick(); clrp = 1'b0;
    ldp = 1'b1; decb = 1'b1; repeat (3) tick(); ldp = 1'b0; decb = 1'b0;
    chk("bzero_product", product, 0);
    finish_op(32'd0);
    chk("bzero_result", result, 0);

    // A = 0
    load_ops(16'd0, 16'd7);
    chk("azero_eqz_low", eqz, 0);
    run_to_zero(n);
    chk("azero_cycles", n, 7);
    chk("azero_product", product, 0);

    // clrp beats ldp
    load_ops(16'd5, 16'd4);
    ldp = 1'b1; repeat (2) tick(); ldp = 1'b0;
    chk("prio_accum", product, 10);
    clrp = 1'b1; ldp = 1'b1; tick(); clrp = 1'b0; ldp = 1'b0;
    chk("prio_clrp_ldp", product, 0);

    // ldb beats decb: B=4 -> 3 -> reload 4
    decb = 1'b1; tick();
    ldb = 1'b1; data_in = 16'd4; tick(); ldb = 1'b0; decb = 1'b0;
    run_to_zero(n);
    chk("prio_ldb_decb_cycles", n, 4);
    chk("prio_ldb_decb_product", product, 20);

    // lda and ldb together load the same value
    lda = 1'b1; ldb = 1'b1; data_in = 16'd6; tick(); lda = 1'b0; ldb = 1'b0;
    clrp = 1'b1; tick(); clrp = 1'b0;
    run_to_zero(n);
    chk("lda_ldb_cycles", n, 6);
    chk("lda_ldb_product", product, 36);
    finish_op(32'd36);

    // narrow instance, max operands 15*15
    s_lda = 1'b1; s_ldb = 1'b1; s_data = 4'd15; tick(); s_lda = 1'b0; s_ldb = 1'b0;
    s_clrp = 1'b1; tick(); s_clrp = 1'b0;
    s_ldp = 1'b1; s_decb = 1'b1; repeat (15) tick();
    chk("small_eqz", s_eqz, 1);
    tick();
    s_ldp = 1'b0; s_decb = 1'b0;
    chk("small_product", s_product, 225);
    s_exp_q.push_back(8'd225);
    s_done = 1'b1; repeat (2) tick(); s_done = 1'b0; tick();
    chk("small_result", s_result, 225);

    // reset mid-operation: B=2, P=20
    load_ops(16'd10, 16'd4);
    ldp = 1'b1; decb = 1'b1; repeat (2) tick(); ldp = 1'b0; decb = 1'b0;
    chk("midrst_pre_product", product, 20);
    chk("midrst_pre_eqz", eqz, 0);
    done = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_product", product, 0);
    chk("midrst_result", result, 0);
    chk("midrst_eqz", eqz, 1);
    chk("midrst_valid", result_valid, 0);
    #4 rst_n = 1'b1;
    repeat (3) tick();
    done = 1'b0;
    tick();
    chk("midrst_result_after", result, 0);
    chk("midrst_product_after", product, 0);

    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 0);
    chk("small_queue_drained", s_exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
